// File: rtl/weight_preload_sequencer.sv
// weight_preload_sequencer
//   Feeds a ROWS x COLS weight matrix from a valid/ready stream into the mesh
//   preload port in row-major order. When the whole matrix is in, it pulses
//   core_start, then waits for core_done. A cycle timeout supervises the run.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   go              start a load batch (IDLE only)
//   abort           cancel the batch in LOAD, START or RUN
//   w_valid/w_ready/w_data             weight stream handshake
//   preload_valid/preload_addr/preload_data   mesh write port; addr = {row, col}
//   core_start      one-cycle start pulse to the core
//   core_done       completion from the core (RUN only)
//   busy            high when not IDLE
//   batch_done      one-cycle pulse on successful completion
//   timeout_err     sticky run-timeout flag, cleared by go or rst
//   loaded_cnt      beats accepted in the current batch
module weight_preload_sequencer #(
  parameter int DW      = 8,
  parameter int ROWS    = 2,
  parameter int COLS    = 4,
  parameter int ROW_W   = 1,
  parameter int COL_W   = 2,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DW-1:0]          w_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   core_start,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   batch_done,
  output logic                   timeout_err,
  output logic [ROW_W+COL_W:0]   loaded_cnt
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [TO_W-1:0]  to_cnt;
  logic             accept;
  logic             last_beat;

  assign w_ready   = (state == LOAD) && !abort;
  assign busy      = (state != IDLE);
  assign accept    = w_valid && w_ready;
  assign last_beat = accept && (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    if (abort) state_nxt = IDLE;
               else if (last_beat) state_nxt = START;
      START:   state_nxt = abort ? IDLE : RUN;
      // to_cnt == TO_LAST marks the TIMEOUT-th RUN cycle
      RUN:     if (abort || core_done || (to_cnt == TO_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      to_cnt        <= '0;
      loaded_cnt    <= '0;
      preload_valid <= 1'b0;
      preload_addr  <= '0;
      preload_data  <= '0;
      core_start    <= 1'b0;
      batch_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      preload_valid <= accept;
      if (accept) begin
        preload_addr <= {row, col};
        preload_data <= w_data;
      end
      core_start <= (state == START) && !abort;
      // core_done beats a timeout landing in the same cycle
      batch_done <= (state == RUN) && !abort && core_done;

      case (state)
        IDLE: begin
          if (go) begin
            row         <= '0;
            col         <= '0;
            loaded_cnt  <= '0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            loaded_cnt <= loaded_cnt + 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        START: to_cnt <= '0;
        RUN: begin
          if (!abort && !core_done) begin
            if (to_cnt == TO_LAST) timeout_err <= 1'b1;
            else                   to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Directed bench for weight_preload_sequencer (2x4 mesh, 8-bit weights, timeout 64).
module tb_weight_preload_sequencer;

  logic       clk = 1'b0;
  logic       rst, go, abort, w_valid, core_done;
  logic [7:0] w_data;
  logic       w_ready, preload_valid, core_start, busy, batch_done, timeout_err;
  logic [2:0] preload_addr;
  logic [7:0] preload_data;
  logic [3:0] loaded_cnt;

  int checks = 0;
  int errors = 0;
  int cs_count = 0;
  int cs_base;

  weight_preload_sequencer #(
    .DW(8), .ROWS(2), .COLS(4), .ROW_W(1), .COL_W(2), .TIMEOUT(64), .TO_W(7)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .preload_valid(preload_valid), .preload_addr(preload_addr),
    .preload_data(preload_data), .core_start(core_start),
    .core_done(core_done), .busy(busy), .batch_done(batch_done),
    .timeout_err(timeout_err), .loaded_cnt(loaded_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) cs_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_w_ready"}, 32'(w_ready), 0);
    chk({tag, "_pv"}, 32'(preload_valid), 0);
    chk({tag, "_paddr"}, 32'(preload_addr), 0);
    chk({tag, "_pdata"}, 32'(preload_data), 0);
    chk({tag, "_start"}, 32'(core_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_bdone"}, 32'(batch_done), 0);
    chk({tag, "_toerr"}, 32'(timeout_err), 0);
    chk({tag, "_cnt"}, 32'(loaded_cnt), 0);
  endtask

  // issue go for one cycle; leaves the DUT in LOAD
  task automatic start_batch();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // push 8 back-to-back beats with data base+i, checking each preload write
  task automatic load_all(input logic [7:0] base, input string tag);
    for (int i = 0; i < 8; i++) begin
      w_valid = 1'b1;
      w_data  = base + 8'(i);
      tick();
      chk({tag, "_pv"}, 32'(preload_valid), 1);
      chk({tag, "_addr"}, 32'(preload_addr), i);
      chk({tag, "_data"}, 32'(preload_data), 32'(base + 8'(i)));
    end
    w_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; w_valid = 1'b0; core_done = 1'b0; w_data = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // ---------------- nominal batch ----------------
    start_batch();
    chk("nom_busy", 32'(busy), 1);
    chk("nom_ready", 32'(w_ready), 1);
    cs_base = cs_count;
    load_all(8'd1, "nom");
    chk("nom_start_state_ready", 32'(w_ready), 0);
    chk("nom_start_not_yet", 32'(core_start), 0);
    chk("nom_cnt8", 32'(loaded_cnt), 8);
    tick();
    chk("nom_core_start", 32'(core_start), 1);
    chk("nom_pv_off", 32'(preload_valid), 0);
    chk("nom_addr_hold", 32'(preload_addr), 7);
    chk("nom_data_hold", 32'(preload_data), 8);
    for (int i = 0; i < 9; i++) tick();
    chk("nom_start_pulse_once", 32'(cs_count - cs_base), 1);
    chk("nom_run_busy", 32'(busy), 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("nom_batch_done", 32'(batch_done), 1);
    chk("nom_idle", 32'(busy), 0);
    chk("nom_cnt_final", 32'(loaded_cnt), 8);
    tick();
    chk("nom_batch_done_pulse", 32'(batch_done), 0);

    // ---------------- bubbly stream, go ignored in LOAD ----------------
    start_batch();
    cs_base = cs_count;
    for (int i = 0; i < 8; i++) begin
      w_valid = 1'b1;
      w_data  = 8'h10 + 8'(i);
      tick();
      chk("bub_pv", 32'(preload_valid), 1);
      chk("bub_addr", 32'(preload_addr), i);
      chk("bub_data", 32'(preload_data), 32'h10 + i);
      w_valid = 1'b0;
      if (i < 7) begin
        if (i == 3) go = 1'b1;
        tick();
        go = 1'b0;
        chk("bub_gap_pv", 32'(preload_valid), 0);
        chk("bub_gap_addr_hold", 32'(preload_addr), i);
        chk("bub_cnt", 32'(loaded_cnt), i + 1);
        tick();
        chk("bub_gap2_pv", 32'(preload_valid), 0);
      end
    end
    tick();
    chk("bub_core_start", 32'(core_start), 1);
    tick();
    chk("bub_core_start_off", 32'(core_start), 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("bub_batch_done", 32'(batch_done), 1);
    chk("bub_single_start", 32'(cs_count - cs_base), 1);

    // ---------------- abort after 5th beat ----------------
    start_batch();
    cs_base = cs_count;
    for (int i = 0; i < 5; i++) begin
      w_valid = 1'b1;
      w_data  = 8'h20 + 8'(i);
      tick();
    end
    chk("abt_addr4", 32'(preload_addr), 4);
    abort  = 1'b1;
    w_data = 8'h99;
    #1;
    chk("abt_ready_drop", 32'(w_ready), 0);
    tick();
    abort = 1'b0; w_valid = 1'b0;
    chk("abt_idle", 32'(busy), 0);
    chk("abt_not_accepted", 32'(preload_valid), 0);
    chk("abt_cnt5", 32'(loaded_cnt), 5);
    tick(); tick();
    chk("abt_no_start", 32'(cs_count - cs_base), 0);
    chk("abt_cnt_hold", 32'(loaded_cnt), 5);

    // ---------------- restart at addr 0, then timeout ----------------
    start_batch();
    chk("rst_cnt_clear", 32'(loaded_cnt), 0);
    load_all(8'h55, "restart");
    tick();
    chk("to_core_start", 32'(core_start), 1);
    for (int i = 0; i < 63; i++) tick();
    chk("to_still_busy", 32'(busy), 1);
    chk("to_not_yet", 32'(timeout_err), 0);
    tick();
    chk("to_err", 32'(timeout_err), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_no_batch_done", 32'(batch_done), 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("to_sticky", 32'(timeout_err), 1);
    chk("idle_core_done_ignored", 32'(batch_done), 0);
    chk("idle_core_done_busy", 32'(busy), 0);

    // ---------------- collision: core_done on the timeout cycle ----------------
    start_batch();
    chk("col_err_cleared", 32'(timeout_err), 0);
    load_all(8'h30, "col");
    tick();
    for (int i = 0; i < 63; i++) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("col_batch_done", 32'(batch_done), 1);
    chk("col_no_err", 32'(timeout_err), 0);
    chk("col_idle", 32'(busy), 0);

    // ---------------- reset mid-run ----------------
    start_batch();
    load_all(8'h40, "rr");
    tick();
    tick();
    chk("rr_in_run", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check_all_zero("rr");
    rst = 1'b0;
    tick();
    check_all_zero("rr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
